// File: rtl/addsub_serial_pkg.sv
// addsub_serial_pkg: shared constants and FSM state type for the serial add/sub unit
package addsub_serial_pkg;
  localparam int WIDTH = 16;
  localparam int NIB = 4;
  localparam int NSTEP = WIDTH / NIB;
  localparam int IW = $clog2(NSTEP);
  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/addsub_nibble_slice.sv
// addsub_nibble_slice: 4-bit ripple adder exposing carry into and out of the top bit
module addsub_nibble_slice
  import addsub_serial_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           c_in,
  output logic [NIB-1:0] s,
  output logic           c3,
  output logic           c_out
);
  logic [NIB:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < NIB; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c3 = c[NIB-1];
  assign c_out = c[NIB];
endmodule

// File: rtl/addsub_16bit_serial.sv
// addsub_16bit_serial: 16-bit add/sub computed one nibble per cycle, with saturation and Z/N/V flags
module addsub_16bit_serial
  import addsub_serial_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Z,
  output logic             N
);
  state_t state;
  logic [IW-1:0] idx;
  logic carry, sat, c3, c_out, ov;
  logic [WIDTH-1:0] a_sh, b_sh, raw, fin;
  logic [WIDTH-NIB-1:0] part;
  logic [NIB-1:0] s;
  addsub_nibble_slice u_slice (
    .a(a_sh[NIB-1:0]),
    .b(b_sh[NIB-1:0]),
    .c_in(carry),
    .s(s),
    .c3(c3),
    .c_out(c_out)
  );
  // raw/ov/fin are only meaningful on the last step, when a_sh[NIB-1] is the original A[15]
  assign raw = {s, part};
  assign ov = c_out ^ c3;
  assign fin = (sat && ov) ? (a_sh[NIB-1] ? SAT_NEG : SAT_POS) : raw;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      Sum <= '0;
      Ovfl <= 1'b0;
      Z <= 1'b0;
      N <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
      sat <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      part <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          a_sh <= a_sh >> NIB;
          b_sh <= b_sh >> NIB;
          part <= raw[WIDTH-1:NIB];
          carry <= c_out;
          idx <= idx + 1'b1;
          if (idx == IW'(NSTEP - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            Sum <= fin;
            Ovfl <= ov;
            Z <= fin == '0;
            N <= fin[WIDTH-1];
          end
        end
        default: begin
          if (start) begin
            state <= RUN;
            busy <= 1'b1;
            a_sh <= A;
            b_sh <= B ^ {WIDTH{sub}};
            sat <= sat_en;
            carry <= sub;
            idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_16bit_serial.sv
// tb_addsub_16bit_serial: directed vectors checked against an arithmetic reference model
module tb_addsub_16bit_serial;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, sat_en = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic busy, done, Ovfl, Z, N;
  logic [15:0] Sum;
  int pass_cnt = 0, total = 0;
  logic [18:0] q[$];
  logic [18:0] cur = '0;
  logic rst_at_edge = 1'b0;
  bit armed = 1'b0;

  addsub_16bit_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub), .sat_en(sat_en),
    .busy(busy), .done(done), .Sum(Sum), .Ovfl(Ovfl), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  // result packing: {ovfl, z, n, sum}
  function automatic logic [18:0] model(logic [15:0] a, logic [15:0] b, logic s, logic sat);
    int r;
    logic ov;
    logic [15:0] f;
    r = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    ov = (r > 32767) || (r < -32768);
    f = (sat && ov) ? (a[15] ? 16'h8000 : 16'h7FFF) : r[15:0];
    return {ov, f == 16'h0000, f[15], f};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    rst_at_edge <= !rst_n;
    if (!rst_n) armed <= 1'b1;
  end

  // every cycle: outputs must equal the last completed result (or zero after reset)
  always @(negedge clk) if (armed) begin
    if (rst_at_edge) begin
      cur = '0;
      q.delete();
    end
    if (done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else cur = q.pop_front();
    end
    chk("outputs", {13'd0, Ovfl, Z, N, Sum}, {13'd0, cur});
  end

  // caller is at a negedge; returns at the negedge where done is high
  task automatic run_op(logic [15:0] a, logic [15:0] b, logic s, logic sat, bit poke);
    A = a; B = b; sub = s; sat_en = sat; start = 1'b1;
    q.push_back(model(a, b, s, sat));
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("busy_run", {30'd0, busy, done}, 32'd2);
      if (poke && k == 1) begin
        start = 1'b1; A = ~a; B = 16'h5555; sub = ~s;
      end else start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", {30'd0, busy, done}, 32'd1);
  endtask

  initial begin
    chk("model_add", {13'd0, model(16'h0001, 16'h0002, 0, 0)}, {13'd0, 3'b000, 16'h0003});
    chk("model_sat_pos", {13'd0, model(16'h7FFF, 16'h0001, 0, 1)}, {13'd0, 3'b100, 16'h7FFF});
    chk("model_wrap", {13'd0, model(16'h7FFF, 16'h0001, 0, 0)}, {13'd0, 3'b101, 16'h8000});
    chk("model_sat_neg", {13'd0, model(16'h8000, 16'h0001, 1, 1)}, {13'd0, 3'b101, 16'h8000});
    chk("model_zero", {13'd0, model(16'h1234, 16'h1234, 1, 0)}, {13'd0, 3'b010, 16'h0000});
    chk("model_carry", {13'd0, model(16'h00F0, 16'h0F10, 0, 0)}, {13'd0, 3'b000, 16'h1000});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", {22'd0, busy, done, Ovfl, Z, N, Sum[4:0]}, 32'd0);
    chk("reset_sum", {16'd0, Sum}, 32'd0);
    @(negedge clk);

    run_op(16'h0001, 16'h0002, 0, 0, 0);
    chk("t1_sum", {16'd0, Sum}, 32'h0003);
    @(negedge clk);
    chk("t1_done_once", {31'd0, done}, 32'd0);
    run_op(16'h7FFF, 16'h0001, 0, 1, 0);
    chk("t2_sat", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b100, 16'h7FFF});
    @(negedge clk);
    run_op(16'h7FFF, 16'h0001, 0, 0, 0);
    chk("t2_wrap", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b101, 16'h8000});
    @(negedge clk);
    run_op(16'h8000, 16'h0001, 1, 1, 0);
    chk("t3_sat_neg", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b101, 16'h8000});
    @(negedge clk);
    run_op(16'h1234, 16'h1234, 1, 0, 0);
    chk("t4_zero", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b010, 16'h0000});
    @(negedge clk);
    run_op(16'h00F0, 16'h0F10, 0, 0, 0);
    chk("t4_carry", {16'd0, Sum}, 32'h1000);
    @(negedge clk);
    run_op(16'h0123, 16'h0456, 0, 0, 1);
    chk("t5_poke_ignored", {16'd0, Sum}, 32'h0579);
    @(negedge clk);
    run_op(16'h8001, 16'h0003, 1, 0, 0);
    run_op(16'h4000, 16'h4000, 0, 0, 0);
    chk("t5_back_to_back", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b101, 16'h8000});
    @(negedge clk);

    A = 16'h0005; B = 16'h0001; sub = 1'b1; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_reset_mid", {22'd0, busy, done, Ovfl, Z, N, Sum[4:0]}, 32'd0);
    chk("t6_reset_sum", {16'd0, Sum}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op(16'h0001, 16'h0002, 0, 0, 0);
    chk("t6_fresh", {13'd0, Ovfl, Z, N, Sum}, {13'd0, 3'b000, 16'h0003});
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
